// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Frame states and the fixed bit positions used by the frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int START_BIT    = 0;
  localparam int DATA_LAST    = 8;
  localparam int MIN_PRESCALE = 8;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter for one UART frame.
// The edge counter wraps at P-1, which advances the bit counter.
module uart_rx_edge_bit_counter #(
  parameter int PS_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            clear_i,
  input  logic [PS_W-1:0] p_i,
  output logic [PS_W-1:0] edge_cnt_o,
  output logic [3:0]      bit_cnt_o,
  output logic            bit_end_o
);

  logic [PS_W-1:0] edge_q, edge_d;
  logic [3:0]      bit_q, bit_d;

  assign bit_end_o  = (edge_q == (p_i - PS_W'(1)));
  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

  // Clear wins over counting so a frame exit lands on 0/0 in the next cycle.
  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clear_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (en_i) begin
      if (bit_end_o) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// Frame-level controller of the UART receiver: start detection, bit timing,
// datapath strobes, glitch rejection and completion/error pulses.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = DATA_LAST,
  parameter int PS_W      = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RX_IN,
  input  logic            PAR_EN,
  input  logic [PS_W-1:0] prescale,
  input  logic            sampled_bit,
  input  logic            par_err,
  input  logic            stp_err,
  output logic [PS_W-1:0] edge_cnt,
  output logic [3:0]      bit_cnt,
  output logic            dat_samp_en,
  output logic            deser_en,
  output logic            par_chk_en,
  output logic            stp_chk_en,
  output logic            data_valid,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  rx_state_e       state_q, state_d;
  logic [PS_W-1:0] p_q, p_d;
  logic            parEn_q, parEn_d;
  logic            perr_q, perr_d;
  logic            dv_q, dv_d;
  logic            fe_q, fe_d;
  logic            pe_q, pe_d;

  logic            cntEn;
  logic            cntClear;
  logic            bitEnd;
  logic            startOk;

  uart_rx_edge_bit_counter #(
    .PS_W(PS_W)
  ) u_counter (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .en_i       (cntEn),
    .clear_i    (cntClear),
    .p_i        (p_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_end_o  (bitEnd)
  );

  assign startOk     = !RX_IN && (prescale >= PS_W'(MIN_PRESCALE));
  assign busy        = (state_q != IDLE);
  assign dat_samp_en = busy;
  assign data_valid  = dv_q;
  assign frame_err   = fe_q;
  assign parity_err  = pe_q;

  // Every decision is taken on the last edge of a bit; P and PAR_EN are frozen at c0.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    parEn_d    = parEn_q;
    perr_d     = perr_q;
    cntEn      = 1'b0;
    cntClear   = 1'b0;
    deser_en   = 1'b0;
    par_chk_en = 1'b0;
    stp_chk_en = 1'b0;
    dv_d       = 1'b0;
    fe_d       = 1'b0;
    pe_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (startOk) begin
          p_d     = prescale;
          parEn_d = PAR_EN;
          perr_d  = 1'b0;
          cntEn   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cntEn = 1'b1;
        if (bitEnd && (bit_cnt == 4'(START_BIT))) begin
          if (sampled_bit) begin
            cntClear = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        cntEn = 1'b1;
        if (bitEnd) begin
          deser_en = 1'b1;
          if (bit_cnt == 4'(DATA_BITS)) begin
            state_d = parEn_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        cntEn = 1'b1;
        if (bitEnd) begin
          par_chk_en = 1'b1;
          perr_d     = par_err;
          state_d    = STOP;
        end
      end
      STOP: begin
        cntEn = 1'b1;
        if (bitEnd) begin
          stp_chk_en = 1'b1;
          cntClear   = 1'b1;
          dv_d       = !stp_err && !perr_q;
          fe_d       = stp_err;
          pe_d       = perr_q;
          state_d    = IDLE;
        end
      end
      default: begin
        cntClear = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      p_q     <= '0;
      parEn_q <= 1'b0;
      perr_q  <= 1'b0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      parEn_q <= parEn_d;
      perr_q  <= perr_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
    end
  end

endmodule
